// File: rtl/gin_pkg.sv
// gin_pkg: shared constants and types for the Global Input Network bus segment.
// The optional broadcast behaviour is selected with the GIN_BROADCAST_EN macro
// (see gin_mc.sv); nothing in this package depends on it.
package gin_pkg;

  // Default geometry of one X-bus segment.
  localparam int GIN_MASTER_NUMS = 14;
  localparam int GIN_ID_LEN      = 4;
  localparam int GIN_VALUE_LEN   = 8;

  // All-ones tag: reserved. It targets no port, or every port when broadcast
  // is enabled. Also the reset value of every port ID.
  localparam logic [GIN_ID_LEN-1:0] GIN_RSVD_TAG = {GIN_ID_LEN{1'b1}};

  // Source word as seen on enable_tag_value, MSB first.
  typedef struct packed {
    logic                     enable;
    logic [GIN_ID_LEN-1:0]    tag;
    logic [GIN_VALUE_LEN-1:0] value;
  } gin_etv_t;

endpackage : gin_pkg

// File: rtl/gin_mc.sv
// gin_mc: per-port multicast controller. It holds one stage of the ID scan
// chain, compares the bus tag against the local ID and produces the port
// enable plus this port's contribution to the bus ready.
// Build option: GIN_BROADCAST_EN -- when defined, the all-ones tag hits every
// port; otherwise the all-ones tag hits nothing.
module gin_mc
  import gin_pkg::*;
#(
  parameter int ID_LEN    = GIN_ID_LEN,
  parameter int VALUE_LEN = GIN_VALUE_LEN
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 set_id_i,
  input  logic [ID_LEN-1:0]    scan_i,
  input  logic                 enable_i,
  input  logic [ID_LEN-1:0]    tag_i,
  input  logic [VALUE_LEN-1:0] value_i,
  input  logic                 master_ready_i,
  output logic [ID_LEN-1:0]    scan_o,
  output logic [VALUE_LEN:0]   enable_data_o,
  output logic                 ready_o
);

  // Reserved tag at this instance's ID width.
  localparam logic [ID_LEN-1:0] RSVD_TAG = {ID_LEN{1'b1}};

  logic [ID_LEN-1:0] id_q;
  logic [ID_LEN-1:0] id_d;
  logic              tag_hit_s;
  logic              port_en_s;

  // Scan stage: shift in the upstream ID while set_id is high, hold otherwise.
  always_comb begin
    id_d = id_q;
    if (set_id_i) begin
      id_d = scan_i;
    end else begin
      id_d = id_q;
    end
  end

  // ID register; reset to the reserved tag so nothing matches until loaded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q <= RSVD_TAG;
    end else begin
      id_q <= id_d;
    end
  end

  // Tag comparator; the reserved tag is decoded before the ID compare.
  always_comb begin
    tag_hit_s = 1'b0;
`ifdef GIN_BROADCAST_EN
    if (tag_i == RSVD_TAG) begin
      tag_hit_s = 1'b1;
    end else begin
      tag_hit_s = (tag_i == id_q);
    end
`else
    if (tag_i == RSVD_TAG) begin
      tag_hit_s = 1'b0;
    end else begin
      tag_hit_s = (tag_i == id_q);
    end
`endif
  end

  // Port enable and ready term; scanning suppresses every delivery.
  always_comb begin
    port_en_s = 1'b0;
    if (set_id_i) begin
      port_en_s = 1'b0;
    end else begin
      port_en_s = enable_i && tag_hit_s;
    end
    // A port that is not addressed never holds the bus back.
    ready_o = (!tag_hit_s) || master_ready_i;
  end

  assign enable_data_o = {port_en_s, value_i};
  assign scan_o        = id_q;

endmodule : gin_mc

// File: rtl/gin_bus.sv
// gin_bus: one GIN bus segment. A single source broadcasts {enable, tag, value}
// to MASTER_NUMS PE ports; only ports whose scanned-in ID equals the tag see
// an asserted enable. The datapath is combinational; only the per-port IDs
// are state. Build option: GIN_BROADCAST_EN (handled inside gin_mc).
module gin_bus
  import gin_pkg::*;
#(
  parameter int MASTER_NUMS = GIN_MASTER_NUMS,
  parameter int ID_LEN      = GIN_ID_LEN,
  parameter int VALUE_LEN   = GIN_VALUE_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_LEN+VALUE_LEN:0] enable_tag_value,
  output logic                      ready,
  input  logic                      master_ready       [MASTER_NUMS],
  output logic [VALUE_LEN:0]        master_enable_data [MASTER_NUMS],
  input  logic                      set_id,
  input  logic [ID_LEN-1:0]         id_scan_in,
  output logic [ID_LEN-1:0]         id_scan_out
);

  logic                   bus_enable_s;
  logic [ID_LEN-1:0]      bus_tag_s;
  logic [VALUE_LEN-1:0]   bus_value_s;
  logic [ID_LEN-1:0]      scan_chain_s [MASTER_NUMS];
  logic [MASTER_NUMS-1:0] ready_term_s;

  // Split the source word into its fields.
  always_comb begin
    bus_enable_s = enable_tag_value[ID_LEN+VALUE_LEN];
    bus_tag_s    = enable_tag_value[ID_LEN+VALUE_LEN-1 -: ID_LEN];
    bus_value_s  = enable_tag_value[VALUE_LEN-1:0];
  end

  for (genvar g = 0; g < MASTER_NUMS; g++) begin : g_port
    logic [ID_LEN-1:0] scan_in_s;

    // Port 0 takes the external scan input; the rest chain from their neighbour.
    if (g == 0) begin : g_head
      assign scan_in_s = id_scan_in;
    end else begin : g_link
      assign scan_in_s = scan_chain_s[g-1];
    end

    gin_mc #(
      .ID_LEN    (ID_LEN),
      .VALUE_LEN (VALUE_LEN)
    ) u_mc (
      .clk_i          (clk),
      .rst_ni         (rst),
      .set_id_i       (set_id),
      .scan_i         (scan_in_s),
      .enable_i       (bus_enable_s),
      .tag_i          (bus_tag_s),
      .value_i        (bus_value_s),
      .master_ready_i (master_ready[g]),
      .scan_o         (scan_chain_s[g]),
      .enable_data_o  (master_enable_data[g]),
      .ready_o        (ready_term_s[g])
    );
  end

  // Bus ready: every addressed port must be ready, and never while scanning.
  always_comb begin
    ready = 1'b0;
    if (set_id) begin
      ready = 1'b0;
    end else begin
      ready = &ready_term_s;
    end
  end

  assign id_scan_out = scan_chain_s[MASTER_NUMS-1];

endmodule : gin_bus

// File: tb/tb_gin_bus.sv
// tb_gin_bus: scoreboard bench for gin_bus. Expected outputs are computed from
// a bench-side ID model when stimulus is driven, queued, and compared when the
// DUT outputs are sampled.
module tb_gin_bus;
  import gin_pkg::*;

  localparam int N = GIN_MASTER_NUMS;

  typedef struct {
    logic        rdy;
    logic [N-1:0] en;
    logic [7:0]  val;
    logic [3:0]  sout;
  } exp_t;

  logic        clk;
  logic        rst;
  gin_etv_t    etv;
  logic        ready;
  logic        master_ready_s [N];
  logic [8:0]  med [N];
  logic        set_id;
  logic [3:0]  id_scan_in;
  logic [3:0]  id_scan_out;
  logic [N-1:0] mr_v;

  logic [3:0]  model_id [N];
  exp_t        sb_q [$];
  int          total;
  int          bad;

  gin_bus dut (
    .clk                (clk),
    .rst                (rst),
    .enable_tag_value   (etv),
    .ready              (ready),
    .master_ready       (master_ready_s),
    .master_enable_data (med),
    .set_id             (set_id),
    .id_scan_in         (id_scan_in),
    .id_scan_out        (id_scan_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) master_ready_s[i] = mr_v[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected bus outputs from the bench ID model and the current inputs.
  task automatic push_exp();
    exp_t e;
    logic hit;
    e.rdy = 1'b1;
    e.en  = '0;
    for (int i = 0; i < N; i++) begin
      hit = (etv.tag == model_id[i]) && (etv.tag != GIN_RSVD_TAG);
`ifdef GIN_BROADCAST_EN
      if (etv.tag == GIN_RSVD_TAG) hit = 1'b1;
`endif
      e.en[i] = etv.enable && hit && !set_id;
      if (hit && !mr_v[i]) e.rdy = 1'b0;
    end
    if (set_id) e.rdy = 1'b0;
    e.val  = etv.value;
    e.sout = model_id[N-1];
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    logic [N-1:0] en_obs;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      for (int i = 0; i < N; i++) en_obs[i] = med[i][8];
      chk("ready", {31'd0, ready}, {31'd0, e.rdy});
      chk("enables", {18'd0, en_obs}, {18'd0, e.en});
      chk("scan_out", {28'd0, id_scan_out}, {28'd0, e.sout});
      for (int i = 0; i < N; i++) chk("value", {24'd0, med[i][7:0]}, {24'd0, e.val});
    end
  endtask

  task automatic model_shift(input logic [3:0] din);
    for (int i = N - 1; i > 0; i--) model_id[i] = model_id[i-1];
    model_id[0] = din;
  endtask

  // One cycle of stimulus: drive off-edge, queue expectation, sample, compare.
  task automatic step(input logic en, input logic [3:0] tag, input logic [7:0] val,
                      input logic set, input logic [3:0] sin, input logic [N-1:0] mr);
    @(negedge clk);
    etv        = '{enable: en, tag: tag, value: val};
    set_id     = set;
    id_scan_in = sin;
    mr_v       = mr;
    #1;
    push_exp();
    #1;
    pop_cmp();
    // The DUT shifts at the coming rising edge; mirror it in the model.
    if (set) model_shift(sin);
  endtask

  initial begin
    logic [3:0] scan_seq [14];
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    etv   = '0;
    set_id = 1'b0;
    id_scan_in = 4'd0;
    mr_v  = {N{1'b1}};
    for (int i = 0; i < N; i++) model_id[i] = GIN_RSVD_TAG;

    // Reset state: no matches, scan out all-ones.
    step(1'b1, 4'd0, 8'h00, 1'b0, 4'd0, {N{1'b1}});
    @(negedge clk);
    rst = 1'b1;

    // Scan load 6..0,6..0 -> id[i] = i mod 7.
    for (int k = 0; k < 14; k++) scan_seq[k] = 4'(6 - (k % 7));
    for (int k = 0; k < 14; k++) step(1'b1, 4'd3, 8'h33, 1'b1, scan_seq[k], {N{1'b1}});
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, {N{1'b1}});
    chk("scan_out_6", {28'd0, id_scan_out}, 32'd6);

    // Multicast: tag 3 hits ports 3 and 10.
    step(1'b1, 4'd3, 8'h03, 1'b0, 4'd0, {N{1'b1}});
    chk("mc_p3", {23'd0, med[3]}, 32'h103);
    chk("mc_p10", {23'd0, med[10]}, 32'h103);

    // Sweep every loaded tag with varied payloads and random ready patterns.
    for (int t = 0; t < 7; t++) begin
      step(1'b1, 4'(t), 8'($urandom_range(0, 255)), 1'b0, 4'd0, N'($urandom));
    end
    step(1'b0, 4'd2, 8'hA5, 1'b0, 4'd0, {N{1'b1}});

    // Backpressure on port 12 while tag 5 addresses ports 5 and 12.
    step(1'b1, 4'd5, 8'hFA, 1'b0, 4'd0, ~(N'(1) << 12));
    step(1'b1, 4'd5, 8'hFA, 1'b0, 4'd0, ~(N'(1) << 12));
    chk("bp_ready_low", {31'd0, ready}, 32'd0);
    step(1'b1, 4'd5, 8'hFA, 1'b0, 4'd0, {N{1'b1}});
    chk("bp_ready_high", {31'd0, ready}, 32'd1);
    // Unaddressed port not ready must not stall.
    step(1'b1, 4'd5, 8'h5A, 1'b0, 4'd0, ~(N'(1) << 3));

    // Reserved tag: dropped, or broadcast when the option is built in.
    step(1'b1, GIN_RSVD_TAG, 8'h7E, 1'b0, 4'd0, {N{1'b1}});
    step(1'b1, GIN_RSVD_TAG, 8'h7F, 1'b0, 4'd0, ~(N'(1) << 0));

    // Scan wins over an active transfer; IDs shift by one.
    step(1'b1, 4'd0, 8'h55, 1'b1, 4'd9, {N{1'b1}});
    step(1'b1, 4'd9, 8'h11, 1'b0, 4'd0, {N{1'b1}});
    step(1'b1, 4'd0, 8'h22, 1'b0, 4'd0, {N{1'b1}});
    step(1'b1, 4'd5, 8'h44, 1'b0, 4'd0, {N{1'b1}});

    // Async reset mid-transfer, away from any clock edge.
    step(1'b1, 4'd2, 8'hC3, 1'b0, 4'd0, {N{1'b1}});
    rst = 1'b0;
    for (int i = 0; i < N; i++) model_id[i] = GIN_RSVD_TAG;
    #1;
    push_exp();
    #1;
    pop_cmp();
    chk("rst_scan_out", {28'd0, id_scan_out}, 32'hF);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 4'd2, 8'hC4, 1'b0, 4'd0, {N{1'b1}});

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_gin_bus
